// File: rtl/audio_level_meter_pkg.sv
// audio_level_meter_pkg: peak FSM states and arithmetic helpers for the level meter
package audio_level_meter_pkg;
  typedef enum logic [1:0] {TRACK, HOLD, DECAY} peak_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v >>= 1) r++;
    return r;
  endfunction
  function automatic int sat_abs(input int x, input int w);
    int m;
    m = (1 << (w - 1)) - 1;
    return (x < 0) ? ((-x > m) ? m : -x) : x;
  endfunction
  function automatic int ashr_sat(input int x, input int sh, input int w);
    return x >>> ((sh > w - 1) ? w - 1 : sh);
  endfunction
endpackage

// File: rtl/audio_level_meter_if.sv
// audio_level_meter_if: multi-channel sample stream with valid/ready handshake
interface audio_level_meter_if #(parameter int DATA_W = 16, parameter int CHANNELS = 2);
  logic [CHANNELS*DATA_W-1:0] sample_in;
  logic sample_valid;
  logic sample_ready;
  modport master(output sample_in, output sample_valid, input sample_ready);
  modport slave(input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_level_meter_channel.sv
// meter_channel: per-channel magnitude, optional DC block (AUDIO_LEVEL_METER_DC_BLOCK_EN), peak hold/decay and clip
module meter_channel
  import audio_level_meter_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 25000000,
  parameter int DECAY_DIV   = 65536,
  parameter int DECAY_SHIFT = 3,
  parameter int CLIP_LEVEL  = 32000
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              clip_clr,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp,
  output logic [DATA_W-2:0] peak,
  output logic              clip
);
  localparam int MW = DATA_W - 1;
  localparam int MAXV = (1 << (DATA_W - 1)) - 1;
  logic [DATA_W-1:0] x_in;
  logic v_in;
`ifdef AUDIO_LEVEL_METER_DC_BLOCK_EN
  logic signed [DATA_W+7:0] avg_q, avg_d;
  logic signed [DATA_W+8:0] diff;
  logic [DATA_W-1:0] y_q, y_d;
  logic yv_q, yv_d;
  int y_i;
  // avg carries 8 fractional bits so the estimate converges to within one LSB
  always_comb begin
    diff = $signed({smp[DATA_W-1], smp, 8'b0}) - $signed({avg_q[DATA_W+7], avg_q});
    avg_d = (smp_valid && !pause) ? avg_q + (DATA_W+8)'(diff >>> 8) : avg_q;
    y_i = int'($signed(smp)) - int'(avg_q >>> 8);
    y_d = DATA_W'((y_i > MAXV) ? MAXV : (y_i < -MAXV - 1) ? -MAXV - 1 : y_i);
    yv_d = smp_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q <= '0;
      y_q   <= '0;
      yv_q  <= 1'b0;
    end else begin
      avg_q <= avg_d;
      y_q   <= y_d;
      yv_q  <= yv_d;
    end
  end
  assign x_in = y_q;
  assign v_in = yv_q;
`else
  assign x_in = smp;
  assign v_in = smp_valid;
`endif
  peak_state_e state_q, state_d;
  logic [MW-1:0] peak_q, peak_d, mag, sh_v, step;
  logic [31:0] hold_q, hold_d, div_q, div_d;
  logic clip_q, clip_d;
  always_comb begin
    state_d = state_q;
    peak_d = peak_q;
    hold_d = hold_q;
    div_d = div_q;
    mag = MW'(sat_abs(int'($signed(x_in)), DATA_W));
    sh_v = peak_q >> DECAY_SHIFT;
    step = (sh_v == '0) ? MW'(1) : sh_v;
    clip_d = (!pause && v_in && int'(mag) >= CLIP_LEVEL) || (clip_q && !clip_clr);
    if (!pause) begin
      if (v_in && mag > peak_q) begin
        peak_d = mag;
        hold_d = 32'(HOLD_CYCLES - 1);
        state_d = HOLD;
      end else if (state_q == HOLD) begin
        state_d = (hold_q == 0) ? DECAY : HOLD;
        div_d = (hold_q == 0) ? 32'(DECAY_DIV - 1) : div_q;
        hold_d = (hold_q == 0) ? hold_q : hold_q - 1;
      end else if (state_q == DECAY) begin
        peak_d = (div_q == 0) ? peak_q - step : peak_q;
        state_d = (div_q == 0 && peak_q == step) ? TRACK : DECAY;
        div_d = (div_q == 0) ? 32'(DECAY_DIV - 1) : div_q - 1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRACK;
      peak_q  <= '0;
      hold_q  <= '0;
      div_q   <= '0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      clip_q  <= clip_d;
    end
  end
  assign peak = peak_q;
  assign clip = clip_q;
endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter: multi-channel scaler, peak meter and LED bar; DC block via AUDIO_LEVEL_METER_DC_BLOCK_EN
module audio_level_meter
  import audio_level_meter_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CHANNELS    = 2,
  parameter int SCALE_W     = 4,
  parameter int BAR_W       = 16,
  parameter int HOLD_CYCLES = 25000000,
  parameter int DECAY_DIV   = 65536,
  parameter int DECAY_SHIFT = 3,
  parameter int CLIP_LEVEL  = 32000,
  localparam int SEL_W      = (CHANNELS > 1) ? clog2(CHANNELS) : 1
)(
  input  logic                CLOCK_50,
  input  logic                reset,
  audio_level_meter_if.slave  s_if,
  input  logic                pause,
  input  logic [SCALE_W-1:0]  scale,
  input  logic [SEL_W-1:0]    chan_sel,
  input  logic                clip_clr,
  output logic [DATA_W-1:0]   scaled_out,
  output logic                scaled_valid,
  output logic [DATA_W-2:0]   peak_out,
  output logic [BAR_W-1:0]    level_bar,
  output logic [CHANNELS-1:0] clip
);
  localparam int BAR_SH = DATA_W - 1 - clog2(BAR_W);
  logic ready_q, ready_d, v1_q, v1_d, sv_q, sv_d, accept;
  logic [CHANNELS*DATA_W-1:0] smp_q, smp_d;
  logic [DATA_W-1:0] scaled_q, scaled_d;
  logic [SEL_W-1:0] sel;
  logic [DATA_W-2:0] peak [CHANNELS];
  always_comb begin
    accept = s_if.sample_valid && ready_q;
    sel = (int'(chan_sel) >= CHANNELS) ? '0 : chan_sel;
    ready_d = 1'b1;
    v1_d = accept;
    smp_d = accept ? s_if.sample_in : smp_q;
    sv_d = accept && !pause;
    scaled_d = sv_d ? DATA_W'(ashr_sat(int'($signed(s_if.sample_in[sel*DATA_W +: DATA_W])), int'(scale), DATA_W)) : scaled_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ready_q  <= 1'b0;
      v1_q     <= 1'b0;
      sv_q     <= 1'b0;
      smp_q    <= '0;
      scaled_q <= '0;
    end else begin
      ready_q  <= ready_d;
      v1_q     <= v1_d;
      sv_q     <= sv_d;
      smp_q    <= smp_d;
      scaled_q <= scaled_d;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    meter_channel #(
      .DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES), .DECAY_DIV(DECAY_DIV),
      .DECAY_SHIFT(DECAY_SHIFT), .CLIP_LEVEL(CLIP_LEVEL)
    ) u_ch (
      .clk(CLOCK_50), .rst(reset), .pause(pause), .clip_clr(clip_clr),
      .smp_valid(v1_q), .smp(smp_q[c*DATA_W +: DATA_W]), .peak(peak[c]), .clip(clip[c])
    );
  end
  always_comb begin
    level_bar = '0;
    for (int i = 0; i < BAR_W; i++) level_bar[i] = int'(peak_out) > (i << BAR_SH);
  end
  assign peak_out = peak[sel];
  assign s_if.sample_ready = ready_q;
  assign scaled_out = scaled_q;
  assign scaled_valid = sv_q;
endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: directed vector table plus hand-timed peak, pause, clip and DC sequences
module tb_audio_level_meter;
`ifdef AUDIO_LEVEL_METER_DC_BLOCK_EN
  localparam int PL = 2;
`else
  localparam int PL = 1;
`endif
  logic CLOCK_50 = 1'b0, reset = 1'b1, pause = 1'b0, clip_clr = 1'b0, chan_sel = 1'b0;
  logic [3:0] scale = 4'd0;
  logic [15:0] scaled_out, level_bar;
  logic scaled_valid;
  logic [14:0] peak_out;
  logic [1:0] clip;
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [3:0]  sc;
    logic        sel;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[8];
  audio_level_meter_if #(.DATA_W(16), .CHANNELS(2)) bus();
  audio_level_meter #(
    .DATA_W(16), .CHANNELS(2), .SCALE_W(4), .BAR_W(16), .HOLD_CYCLES(8),
    .DECAY_DIV(4), .DECAY_SHIFT(3), .CLIP_LEVEL(32000)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .s_if(bus), .pause(pause), .scale(scale),
    .chan_sel(chan_sel), .clip_clr(clip_clr), .scaled_out(scaled_out),
    .scaled_valid(scaled_valid), .peak_out(peak_out), .level_bar(level_bar), .clip(clip)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", n, a, a, e, e);
    end
  endtask
  task automatic send(input logic [15:0] s0, input logic [15:0] s1);
    bus.sample_in = {s1, s0};
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask
  task automatic rst_dut();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    pause = 1'b0;
    clip_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit done;
    vt[0] = '{16'h8000, 16'h0000, 4'd3,  1'b0, 16'hF000};
    vt[1] = '{16'h8000, 16'h0000, 4'd15, 1'b0, 16'hFFFF};
    vt[2] = '{16'h7FFF, 16'h0000, 4'd0,  1'b0, 16'h7FFF};
    vt[3] = '{16'h7FFF, 16'h0000, 4'd15, 1'b0, 16'h0000};
    vt[4] = '{16'h1234, 16'hC000, 4'd4,  1'b1, 16'hFC00};
    vt[5] = '{16'h1234, 16'h0100, 4'd8,  1'b1, 16'h0001};
    vt[6] = '{16'hFFFF, 16'h0000, 4'd5,  1'b0, 16'hFFFF};
    vt[7] = '{16'h8001, 16'h0000, 4'd1,  1'b0, 16'hC000};
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus.sample_ready, 0);
    chk("rst_scaled", scaled_out, 0);
    chk("rst_svalid", scaled_valid, 0);
    chk("rst_peak", peak_out, 0);
    chk("rst_bar", level_bar, 0);
    chk("rst_clip", clip, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", bus.sample_ready, 1);
    for (int i = 0; i < 8; i++) begin
      bus.sample_in = {vt[i].s1, vt[i].s0};
      scale = vt[i].sc;
      chan_sel = vt[i].sel;
      bus.sample_valid = 1'b1;
      tick();
      chk($sformatf("scaled_v%0d", i), scaled_out, vt[i].exp);
      chk($sformatf("svalid_v%0d", i), scaled_valid, 1);
    end
    bus.sample_valid = 1'b0;
    tick();
    chk("svalid_drop", scaled_valid, 0);
    chk("scaled_hold", scaled_out, 16'hC000);
    rst_dut();
    chan_sel = 1'b0;
    send(16'd1000, 16'd0);
    repeat (PL) tick();
    chk("hold_bar", level_bar, 16'h0001);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("hold_peak_%0d", i), peak_out, 1000);
      tick();
    end
    chk("decay1", peak_out, 875);
    repeat (3) tick();
    chk("decay1_hold", peak_out, 875);
    tick();
    chk("decay2", peak_out, 766);
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      done = (peak_out == 0);
    end
    chk("decay_to_zero", {31'd0, done}, 1);
    repeat (5) tick();
    chk("track_idle_peak", peak_out, 0);
    chk("track_idle_bar", level_bar, 0);
    rst_dut();
    scale = 4'd0;
    send(16'd500, 16'd0);
    repeat (PL) tick();
    repeat (9) tick();
    chk("pause_pre", peak_out, 500);
    pause = 1'b1;
    bus.sample_in = {16'd0, 16'd2000};
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) bus.sample_valid = 1'b0;
      chk($sformatf("pause_peak_%0d", i), peak_out, 500);
      chk($sformatf("pause_svalid_%0d", i), scaled_valid, 0);
    end
    chk("pause_scaled_hold", scaled_out, 500);
    pause = 1'b0;
    tick();
    tick();
    chk("resume_before", peak_out, 500);
    tick();
    chk("resume_decay", peak_out, 438);
    rst_dut();
    chan_sel = 1'b1;
    send(16'd0, 16'd31999);
    repeat (PL) tick();
    chk("clip_below", clip, 2'b00);
    chk("peak_31999", peak_out, 31999);
    rst_dut();
    send(16'd0, 16'd32000);
    repeat (PL) tick();
    chk("clip_at_level", clip, 2'b10);
    rst_dut();
    send(16'd0, 16'h8000);
    repeat (PL) tick();
    chk("peak_maxneg", peak_out, 15'h7FFF);
    chk("bar_full", level_bar, 16'hFFFF);
    chk("clip_set", clip, 2'b10);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    chk("clip_clr", clip, 2'b00);
    send(16'd0, 16'd32001);
    repeat (PL - 1) tick();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    chk("clip_set_wins", clip, 2'b10);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    pause = 1'b1;
    send(16'd0, 16'h8000);
    repeat (PL) tick();
    pause = 1'b0;
    chk("clip_paused", clip, 2'b00);
    rst_dut();
    chan_sel = 1'b0;
    bus.sample_in = {16'd4000, 16'd4000};
    bus.sample_valid = 1'b1;
    repeat (3) tick();
    chk("const_peak_start", peak_out, 4000);
    repeat (4093) tick();
    bus.sample_valid = 1'b0;
`ifdef AUDIO_LEVEL_METER_DC_BLOCK_EN
    chk("dc_bar_low", {31'd0, level_bar <= 16'h0001}, 1);
`else
    chk("const_bar", level_bar, 16'h0003);
    chk("const_peak_range", {31'd0, peak_out >= 15'd3500 && peak_out <= 15'd4000}, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
- Parametrised, multi-channel successor to the single-channel scale-and-LED display path of the voice-recorder top level.
- Per channel: accepts signed PCM samples over a valid/ready handshake and produces a selectable arithmetic-shift-scaled sample for the VGA trace.
- Also tracks peak magnitude per channel, with hold and decay, drives a thermometer LED bar and a sticky clip flag.
- Sits between Audio_Controller/playrec and the display/LED logic.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- CHANNELS, 2: number of independent channels.
- SCALE_W, 4: width of the scale (right-shift) control.
- BAR_W, 16: LED bar length; must be a power of two, ≤ 2^(DATA_W-1).
- HOLD_CYCLES, 25000000: clocks the peak is held after its last increase.
- DECAY_DIV, 65536: clocks between decay steps once hold expires.
- DECAY_SHIFT, 3: decay step is peak>>DECAY_SHIFT, minimum 1.
- CLIP_LEVEL, 32000: magnitude at or above which clip is set.

Ports:
- CLOCK_50, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- sample_in, in, CHANNELS*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- sample_valid, in, 1: sample_in is valid.
- sample_ready, out, 1: block accepts a sample this cycle.
- pause, in, 1: freezes meter state.
- scale, in, SCALE_W: arithmetic right-shift amount.
- chan_sel, in, max(1,$clog2(CHANNELS)): channel routed to scaled_out, peak_out and level_bar.
- clip_clr, in, 1: one-cycle pulse that clears all clip flags.
- scaled_out, out, DATA_W: scaled sample of chan_sel.
- scaled_valid, out, 1: one-cycle strobe, scaled_out updated.
- peak_out, out, DATA_W-1: held peak magnitude of chan_sel.
- level_bar, out, BAR_W: thermometer code of peak_out.
- clip, out, CHANNELS: sticky clip flag per channel.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-high. All registers update on posedge CLOCK_50.
- Reset values: sample_ready=0, scaled_out=0, scaled_valid=0, peak_out=0, level_bar=0, clip=0. All hold and decay counters are 0 and every pipeline valid is cleared. Reset mid-operation discards in-flight samples.
- Handshake:
  - sample_ready is a register: 0 in the reset cycle, 1 from the first cycle after reset is released.
  - A sample is accepted when sample_valid && sample_ready. There is no backpressure beyond reset.
- Stage 1, latency 1 cycle after acceptance:
  - Register all channels.
  - scaled = sample >>> scale, sign-extending. Any scale ≥ DATA_W-1 gives all sign bits.
  - scaled_out and scaled_valid are driven from the chan_sel channel.
  - While pause=1, scaled_out holds and scaled_valid stays 0; samples are still accepted and dropped.
- Stage 2, latency 2 cycles: compute mag = |sample| per channel from the unscaled sample, saturating. The most-negative value maps to 2^(DATA_W-1)-1.
- Peak state machine, per channel; states TRACK, HOLD, DECAY:
  - Any state, pause=0, new mag > peak: peak←mag, hold_cnt←HOLD_CYCLES-1, state←HOLD.
  - HOLD: hold_cnt decrements each clock. At 0: state←DECAY, div_cnt←DECAY_DIV-1.
  - DECAY: every DECAY_DIV clocks, peak←peak−max(1, peak>>DECAY_SHIFT). When peak reaches 0, state←TRACK.
  - TRACK: idle at peak=0.
  - A new mag equal to peak does not reload the hold counter.
  - pause=1 freezes peak, counters and state.
- Clip:
  - clip[c] is set when accepted mag ≥ CLIP_LEVEL and pause=0.
  - clip_clr clears all flags. If clip_clr and a set occur in the same cycle, set wins.
- level_bar:
  - Combinational from the registered peak_out.
  - Bit i=1 iff peak_out > (i << (DATA_W-1-log2(BAR_W))). Bit 0 lights for any non-zero peak.
- chan_sel ≥ CHANNELS selects channel 0.

Optional Feature:
- Macro: AUDIO_LEVEL_METER_DC_BLOCK_EN.
- Defined: each channel subtracts a running DC estimate before the magnitude stage.
  - avg←avg+((x−avg)>>>8), DATA_W+8 bits internal.
  - y=x−avg, saturated to DATA_W.
  - Adds 1 cycle to peak latency; scaled_out is unaffected.
- Undefined: magnitude is computed from the raw sample, and no avg registers exist.

Decomposition:
- Package audio_level_meter_pkg holds:
  - the peak state enum (TRACK/HOLD/DECAY);
  - the sat_abs and ashr_sat functions;
  - a clog2 helper.
- Sub-module meter_channel: one channel's magnitude, DC block, peak FSM and clip logic. It is instantiated CHANNELS times via generate.
- The top handles the handshake, scaling and channel mux.

Test Plan:
- Reset release, CHANNELS=2 → sample_ready=0 in the reset cycle, then 1; all outputs 0.
- Accept ch0=16'h8000, scale=3 → next cycle scaled_out=16'hF000 and scaled_valid=1; scale=15 → 16'hFFFF.
- HOLD_CYCLES=8, DECAY_DIV=4, DECAY_SHIFT=3: ch0=1000 then zeros → peak_out=1000 for 8 clocks after update. Then decays to 875 after 4 clocks, 766 after 4 more, and finally reaches 0 in TRACK.
- ch1=−32768 → peak=32767, level_bar=16'hFFFF, clip[1]=1; clip_clr in the same cycle as a ch1 sample of 32001 → clip[1] stays 1.
- pause=1 during DECAY with peak=500 → peak_out stays 500 and scaled_valid stays 0 for 20 clocks; on release, decay resumes.
- With AUDIO_LEVEL_METER_DC_BLOCK_EN defined: constant input 4000 for 4096 samples → peak decays and bar drops to ≤1 LED. Without the macro: peak_out=4000 and 2 LEDs lit.
